// File: rtl/mem_bridge_if.sv
// Control-side request/response and shared-memory bus signals of mem_bridge.
// slave is the bridge's view; master is the view of whatever drives control and bus.
interface mem_bridge_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              mem_rd;
    logic              mem_wr;
    logic              IorD;
    logic [31:0]       pc;
    logic [31:0]       alu_out;
    logic [31:0]       wdata;
    logic              mem_busy;
    logic              mem_done;
    logic              mem_err;
    logic [31:0]       rdata;
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [31:0]       bus_wdata;
    logic              bus_ack;
    logic [31:0]       bus_rdata;

    modport slave (
        input  mem_rd, mem_wr, IorD, pc, alu_out, wdata, bus_ack, bus_rdata,
        output mem_busy, mem_done, mem_err, rdata, bus_req, bus_we, bus_addr, bus_wdata
    );

    modport master (
        output mem_rd, mem_wr, IorD, pc, alu_out, wdata, bus_ack, bus_rdata,
        input  mem_busy, mem_done, mem_err, rdata, bus_req, bus_we, bus_addr, bus_wdata
    );
endinterface

// File: rtl/mem_bridge.sv
// Multicycle memory access unit: turns control-FSM level requests into one req/ack
// bus transaction with alignment and timeout checks, and returns a one-cycle done pulse.
module mem_bridge #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    mem_bridge_if.slave mif
);
    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

    state_e              r_state, w_state;
    logic                r_busy, w_busy;
    logic                r_done, w_done;
    logic                r_err, w_err;
    logic                r_req, w_req;
    logic                r_we, w_we;
    logic [ADDR_W-1:0]   r_addr, w_addr;
    logic [31:0]         r_wdata, w_wdata;
    logic [31:0]         r_rdata, w_rdata;
    logic [CntW-1:0]     r_cnt, w_cnt;
    logic [31:0]         w_sel_addr;

    assign w_sel_addr = mif.IorD ? mif.alu_out : mif.pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_err   <= w_err;
            r_req   <= w_req;
            r_we    <= w_we;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
            r_rdata <= w_rdata;
            r_cnt   <= w_cnt;
        end
    end

    // Output registers are loaded on the transition into a state, so each output
    // reflects the state it belongs to without any combinational decode.
    always_comb begin
        w_state = r_state;
        w_busy  = r_busy;
        w_done  = 1'b0;
        w_err   = 1'b0;
        w_req   = r_req;
        w_we    = r_we;
        w_addr  = r_addr;
        w_wdata = r_wdata;
        w_rdata = r_rdata;
        w_cnt   = r_cnt;
        unique case (r_state)
            StIdle: begin
                if (mif.mem_rd || mif.mem_wr) begin
                    if (w_sel_addr[1:0] != 2'b00) begin
                        w_state = StDone;
                        w_done  = 1'b1;
                        w_err   = 1'b1;
                    end else begin
                        w_state = StReq;
                        w_req   = 1'b1;
                        w_busy  = 1'b1;
                        w_we    = mif.mem_wr;
                        w_addr  = w_sel_addr[ADDR_W-1:0];
                        w_wdata = mif.wdata;
                        w_cnt   = '0;
                    end
                end
            end
            StReq: begin
                // Ack is tested first so a same-cycle ack beats the timeout.
                if (mif.bus_ack) begin
                    w_state = StDone;
                    w_req   = 1'b0;
                    w_busy  = 1'b0;
                    w_done  = 1'b1;
                    if (!r_we) w_rdata = mif.bus_rdata;
                end else if (r_cnt == CntW'(TIMEOUT - 1)) begin
                    w_state = StDone;
                    w_req   = 1'b0;
                    w_busy  = 1'b0;
                    w_done  = 1'b1;
                    w_err   = 1'b1;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            StDone: w_state = StIdle;
            default: w_state = StIdle;
        endcase
    end

    assign mif.mem_busy  = r_busy;
    assign mif.mem_done  = r_done;
    assign mif.mem_err   = r_err;
    assign mif.rdata     = r_rdata;
    assign mif.bus_req   = r_req;
    assign mif.bus_we    = r_we;
    assign mif.bus_addr  = r_addr;
    assign mif.bus_wdata = r_wdata;
endmodule

// File: tb/tb_mem_bridge.sv
// Self-checking bench for mem_bridge: directed scenarios plus randomized accesses
// compared cycle by cycle against a transaction-level expectation.
module tb_mem_bridge;
    localparam int unsigned TO = 4;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    logic [31:0] model_rdata;

    mem_bridge_if #(.ADDR_W(32)) mif ();

    mem_bridge #(.ADDR_W(32), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mif   (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One access; d = bus_req cycle on which ack is returned (d > TO means never).
    // Expected timing follows from the rules: bus_req on cycles 1..k, done on k+1.
    task automatic run_access(input string nm, input bit rd, input bit wr, input bit iord,
                              input logic [31:0] pc_v, input logic [31:0] alu_v,
                              input logic [31:0] wd_v, input int d,
                              input logic [31:0] ack_data, input bit noise);
        logic [31:0] addr;
        bit aligned, exp_err, exp_req, exp_done;
        int k, done_cyc;
        addr    = iord ? alu_v : pc_v;
        aligned = (addr[1:0] == 2'b00);
        if (aligned) begin
            k       = (d <= int'(TO)) ? d : int'(TO);
            exp_err = (d > int'(TO));
        end else begin
            k       = 0;
            exp_err = 1'b1;
        end
        done_cyc = k + 1;
        mif.mem_rd    = rd;
        mif.mem_wr    = wr;
        mif.IorD      = iord;
        mif.pc        = pc_v;
        mif.alu_out   = alu_v;
        mif.wdata     = wd_v;
        mif.bus_ack   = noise;
        mif.bus_rdata = $urandom;
        for (int n = 1; n <= done_cyc + 1; n++) begin
            @(posedge clk);
            #1;
            exp_req  = aligned && (n <= k);
            exp_done = (n == done_cyc);
            n_checks += 4;
            if (mif.bus_req !== exp_req) begin
                n_errors++;
                $display("FAIL %s bus_req cyc%0d: got %b exp %b", nm, n, mif.bus_req, exp_req);
            end
            if (mif.mem_busy !== exp_req) begin
                n_errors++;
                $display("FAIL %s mem_busy cyc%0d: got %b exp %b", nm, n, mif.mem_busy, exp_req);
            end
            if (mif.mem_done !== exp_done) begin
                n_errors++;
                $display("FAIL %s mem_done cyc%0d: got %b exp %b", nm, n, mif.mem_done, exp_done);
            end
            if (mif.mem_err !== (exp_done && exp_err)) begin
                n_errors++;
                $display("FAIL %s mem_err cyc%0d: got %b exp %b", nm, n, mif.mem_err,
                         exp_done && exp_err);
            end
            if (exp_req) begin
                n_checks += 3;
                if (mif.bus_addr !== addr) begin
                    n_errors++;
                    $display("FAIL %s bus_addr cyc%0d: got %h exp %h", nm, n, mif.bus_addr, addr);
                end
                if (mif.bus_we !== wr) begin
                    n_errors++;
                    $display("FAIL %s bus_we cyc%0d: got %b exp %b", nm, n, mif.bus_we, wr);
                end
                if (mif.bus_wdata !== wd_v) begin
                    n_errors++;
                    $display("FAIL %s bus_wdata cyc%0d: got %h exp %h", nm, n, mif.bus_wdata, wd_v);
                end
            end
            if (n == done_cyc && aligned && !exp_err && !wr) model_rdata = ack_data;
            if (n >= done_cyc) begin
                n_checks++;
                if (mif.rdata !== model_rdata) begin
                    n_errors++;
                    $display("FAIL %s rdata cyc%0d: got %h exp %h", nm, n, mif.rdata, model_rdata);
                end
            end
            // Inputs other than the request are don't-care once the access is launched.
            mif.pc      = $urandom;
            mif.alu_out = $urandom;
            mif.wdata   = $urandom;
            mif.IorD    = 1'($urandom);
            if (aligned && n == d && d <= int'(TO)) begin
                mif.bus_ack   = 1'b1;
                mif.bus_rdata = ack_data;
            end else begin
                mif.bus_ack   = noise && (n == done_cyc);
                mif.bus_rdata = $urandom;
            end
            if (n == done_cyc) begin
                mif.mem_rd = 1'b0;
                mif.mem_wr = 1'b0;
            end
        end
        mif.bus_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        mif.mem_rd  = 1'b0;
        mif.mem_wr  = 1'b0;
        mif.IorD    = 1'b0;
        mif.pc      = '0;
        mif.alu_out = '0;
        mif.wdata   = '0;
        mif.bus_ack = 1'b0;
        mif.bus_rdata = '0;
        model_rdata = '0;
        #1;
        n_checks++;
        if ({mif.mem_busy, mif.mem_done, mif.mem_err, mif.bus_req, mif.bus_we} !== 5'b0 ||
            mif.rdata !== 32'h0 || mif.bus_addr !== 32'h0 || mif.bus_wdata !== 32'h0) begin
            n_errors++;
            $display("FAIL reset outputs: got req=%b done=%b rdata=%h addr=%h wdata=%h exp all 0",
                     mif.bus_req, mif.mem_done, mif.rdata, mif.bus_addr, mif.bus_wdata);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        run_access("fetch", 1, 0, 0, 32'h0000_3000, 32'h0, 32'h0, 2, 32'h2008_0005, 0);
        run_access("store", 0, 1, 1, 32'h0, 32'h0000_1004, 32'hDEAD_BEEF, 1, 32'h5555_AAAA, 0);
        run_access("misalign", 1, 0, 1, 32'h0, 32'h0000_1002, 32'h0, 1, 32'h1111_2222, 0);
        run_access("timeout", 1, 0, 0, 32'h0000_0100, 32'h0, 32'h0, TO + 1, 32'h3333_4444, 0);
        run_access("ack_at_limit", 1, 0, 0, 32'h0000_0104, 32'h0, 32'h0, TO, 32'hCAFE_F00D, 0);
        run_access("rd_wr_prio", 1, 1, 1, 32'h0, 32'h0000_0200, 32'h0BAD_C0DE, 1, 32'h7777_7777, 1);
    endtask

    task automatic test_back_to_back();
        bit exp_req, exp_done;
        mif.mem_rd  = 1'b1;
        mif.mem_wr  = 1'b1;
        mif.IorD    = 1'b1;
        mif.alu_out = 32'h0000_2000;
        mif.wdata   = 32'h1234_5678;
        mif.bus_ack = 1'b0;
        for (int n = 1; n <= 6; n++) begin
            @(posedge clk);
            #1;
            exp_req  = (n == 1) || (n == 4);
            exp_done = (n == 2) || (n == 5);
            n_checks += 2;
            if (mif.bus_req !== exp_req) begin
                n_errors++;
                $display("FAIL b2b bus_req cyc%0d: got %b exp %b", n, mif.bus_req, exp_req);
            end
            if (mif.mem_done !== exp_done) begin
                n_errors++;
                $display("FAIL b2b mem_done cyc%0d: got %b exp %b", n, mif.mem_done, exp_done);
            end
            if (exp_req) begin
                n_checks++;
                if (mif.bus_we !== 1'b1) begin
                    n_errors++;
                    $display("FAIL b2b bus_we cyc%0d: got %b exp 1", n, mif.bus_we);
                end
            end
            mif.bus_ack = exp_req;
            if (n == 5) begin
                mif.mem_rd = 1'b0;
                mif.mem_wr = 1'b0;
            end
        end
        mif.bus_ack = 1'b0;
    endtask

    task automatic test_reset_mid();
        mif.mem_rd = 1'b1;
        mif.mem_wr = 1'b0;
        mif.IorD   = 1'b0;
        mif.pc     = 32'h0000_0040;
        @(posedge clk);
        #1;
        n_checks++;
        if (mif.bus_req !== 1'b1) begin
            n_errors++;
            $display("FAIL rst_mid pre bus_req: got %b exp 1", mif.bus_req);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks += 2;
        if (mif.bus_req !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_mid async bus_req: got %b exp 0", mif.bus_req);
        end
        if (mif.mem_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_mid async mem_busy: got %b exp 0", mif.mem_busy);
        end
        model_rdata = '0;
        mif.mem_rd  = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (mif.mem_done !== 1'b0) begin
                n_errors++;
                $display("FAIL rst_mid mem_done: got %b exp 0", mif.mem_done);
            end
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_access("post_rst_fetch", 1, 0, 0, 32'h0000_0040, 32'h0, 32'h0, 1, 32'h8765_4321, 0);
    endtask

    task automatic test_random();
        bit rd, wr, iord;
        logic [31:0] a;
        for (int i = 0; i < 30; i++) begin
            rd = 1'($urandom);
            wr = 1'($urandom);
            if (!rd && !wr) rd = 1'b1;
            iord = 1'($urandom);
            a = $urandom;
            if ($urandom_range(3) != 0) a[1:0] = 2'b00;
            run_access("random", rd, wr, iord, iord ? $urandom : a, iord ? a : $urandom,
                       $urandom, int'($urandom_range(TO + 2, 1)), $urandom, 1'($urandom));
            if ($urandom_range(1) == 1) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
